bist_receiver: RTL and testbench

BIST_RECEIVER -- requirements
Module: bist_receiver

---
 rtl/bist_pkg.sv | 37 +++
 rtl/bist_lfsr.sv | 39 +++
 rtl/bist_receiver.sv | 141 ++++++++++++++
 tb/tb_bist_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared definitions for the BIST sender/receiver pair: LFSR
//               polynomial and width, pattern generation helpers, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

  localparam int unsigned LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // One Galois step: shift right, fold the polynomial in when a one drops out.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    logic [LFSR_WIDTH-1:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LFSR_POLY;
    end
    return r;
  endfunction

  // Bit idx of the pattern bus: the LFSR state replicated LSB-first.
  function automatic logic expand(input logic [LFSR_WIDTH-1:0] s, input int unsigned idx);
    logic [4:0] sel;
    sel = 5'(idx % LFSR_WIDTH);
    return s[sel];
  endfunction

endpackage : bist_pkg
`default_nettype wire

// File: rtl/bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : bist_lfsr
// Description : Seeded Galois LFSR that steps once per cycle when advance is
//               high. Shared by the BIST sender and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr
  import bist_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED  = 32'hdeadbeef,
  parameter int unsigned           WIDTH = LFSR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  // The step function is only defined for the package LFSR width.
  if (WIDTH != LFSR_WIDTH) begin : g_width_check
    $error("bist_lfsr: WIDTH must equal LFSR_WIDTH");
  end

  logic [WIDTH-1:0] state_q;

  // State register: reloads the seed on reset, steps on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule : bist_lfsr
`default_nettype wire

// File: rtl/bist_receiver.sv
`default_nettype none
// ============================================================================
// Module      : bist_receiver
// Description : Checks TEST_CASES back-to-back LFSR patterns arriving on
//               input_channels after a start pulse and reports a registered
//               verdict (done/pass), saturating error count, index of the
//               first failing pattern and a sticky per-channel mismatch mask.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_receiver
  import bist_pkg::*;
#(
  parameter int unsigned           TEST_CHANNELS = 70,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 32'hdeadbeef,
  parameter int unsigned           TEST_CASES    = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [TEST_CHANNELS-1:0]          input_channels,
  output logic                              done,
  output logic                              pass,
  output logic [15:0]                       error_count,
  output logic [$clog2(TEST_CASES+1)-1:0]   first_fail_index,
  output logic [TEST_CHANNELS-1:0]          mismatch_mask
);

  localparam int unsigned      IDX_W    = $clog2(TEST_CASES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEST_CASES - 1);
  localparam logic [15:0]      ERR_MAX  = 16'hFFFF;

  // An all-zero seed locks the LFSR at zero, so it can never match the sender.
  if (SEED == '0) begin : g_seed_check
    $error("bist_receiver: SEED must be non-zero");
  end

  if (TEST_CASES < 1) begin : g_cases_check
    $error("bist_receiver: TEST_CASES must be at least 1");
  end

  bist_state_e              state_q, state_d;
  logic [IDX_W-1:0]         case_q, case_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [15:0]              err_q, err_d;
  logic [IDX_W-1:0]         ff_q, ff_d;
  logic [TEST_CHANNELS-1:0] mask_q, mask_d;

  logic                     check;
  logic                     last_case;
  logic [LFSR_WIDTH-1:0]    lfsr_state;
  logic [TEST_CHANNELS-1:0] expected;
  logic [TEST_CHANNELS-1:0] diff;

  // The LFSR holds the expected state for the case currently being checked;
  // it steps in lock-step with every comparison.
  bist_lfsr #(
    .SEED  (SEED),
    .WIDTH (LFSR_WIDTH)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (check),
    .state   (lfsr_state)
  );

  for (genvar i = 0; i < int'(TEST_CHANNELS); i++) begin : g_expand
    assign expected[i] = expand(lfsr_state, i);
  end

  assign diff      = input_channels ^ expected;
  assign last_case = (case_q == LAST_IDX);

  // Next-state logic: a comparison happens on the start edge and on every RUN edge.
  always_comb begin
    state_d = state_q;
    case_d  = case_q;
    check   = 1'b0;
    unique case (state_q)
      ST_IDLE: check = start;
      ST_RUN:  check = 1'b1;
      ST_DONE: check = 1'b0;
      default: state_d = ST_IDLE;
    endcase
    if (check) begin
      case_d  = case_q + 1'b1;
      state_d = last_case ? ST_DONE : ST_RUN;
    end
  end

  // Verdict accumulation; pass is resolved on the same edge that sets done.
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    ff_d   = ff_q;
    mask_d = mask_q;
    if (check && (diff != '0)) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == 16'd0) begin
        ff_d = case_q;
      end
      mask_d = mask_q | diff;
    end
    if (check && last_case) begin
      done_d = 1'b1;
      pass_d = (err_d == 16'd0);
    end
  end

  // Control and verdict registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      case_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 16'd0;
      ff_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      case_q  <= case_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      mask_q  <= mask_d;
    end
  end

  assign done             = done_q;
  assign pass             = pass_q;
  assign error_count      = err_q;
  assign first_fail_index = ff_q;
  assign mismatch_mask    = mask_q;

endmodule : bist_receiver
`default_nettype wire

// File: tb/tb_bist_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bist_receiver
// Description : Self-checking bench for bist_receiver: default build against a
//               behavioural model, plus a TEST_CASES=1 build and a
//               TEST_CASES=70000 saturation build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_receiver;

  localparam int          NCH    = 70;
  localparam int          NCASE  = 1000;
  localparam int          NSAT   = 70000;
  localparam logic [31:0] SEED_V = 32'hdeadbeef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- default build ----------------
  logic           rst_m = 1'b0, start_m = 1'b0;
  logic [NCH-1:0] ch_m = '0;
  logic           done_m, pass_m;
  logic [15:0]    err_m;
  logic [9:0]     ff_m;
  logic [NCH-1:0] mask_m;

  bist_receiver #(.TEST_CHANNELS(NCH), .SEED(SEED_V), .TEST_CASES(NCASE)) dut (
    .clk(clk), .reset(rst_m), .start(start_m), .input_channels(ch_m),
    .done(done_m), .pass(pass_m), .error_count(err_m),
    .first_fail_index(ff_m), .mismatch_mask(mask_m));

  // ---------------- single-case build ----------------
  logic           rst_1 = 1'b0, start_1 = 1'b0;
  logic [NCH-1:0] ch_1 = '0;
  logic           done_1, pass_1;
  logic [15:0]    err_1;
  logic [0:0]     ff_1;
  logic [NCH-1:0] mask_1;

  bist_receiver #(.TEST_CHANNELS(NCH), .SEED(SEED_V), .TEST_CASES(1)) dut1 (
    .clk(clk), .reset(rst_1), .start(start_1), .input_channels(ch_1),
    .done(done_1), .pass(pass_1), .error_count(err_1),
    .first_fail_index(ff_1), .mismatch_mask(mask_1));

  // ---------------- saturation build ----------------
  logic           rst_s = 1'b0, start_s = 1'b0;
  logic [NCH-1:0] ch_s = '0;
  logic           done_s, pass_s;
  logic [15:0]    err_s;
  logic [16:0]    ff_s;
  logic [NCH-1:0] mask_s;
  logic           sat_finished = 1'b0;

  bist_receiver #(.TEST_CHANNELS(NCH), .SEED(SEED_V), .TEST_CASES(NSAT)) dut_sat (
    .clk(clk), .reset(rst_s), .start(start_s), .input_channels(ch_s),
    .done(done_s), .pass(pass_s), .error_count(err_s),
    .first_fail_index(ff_s), .mismatch_mask(mask_s));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pattern generation, written from the LFSR definition.
  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [NCH-1:0] widen(input logic [31:0] s);
    logic [NCH-1:0] w;
    for (int i = 0; i < NCH; i++) w[i] = s[i % 32];
    return w;
  endfunction

  function automatic logic [NCH-1:0] rand70();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NCH-1:0];
  endfunction

  logic [NCH-1:0] exp_tab [NCASE];

  // Stimulus variants: 0 clean, 1 bit 5 flipped in case 17, 2 bit 69 stuck low, 3 random flips
  function automatic logic [NCH-1:0] pat(input int k, input int mode);
    logic [NCH-1:0] p;
    p = exp_tab[k];
    if (mode == 1 && k == 17) p[5] = ~p[5];
    if (mode == 2) p[69] = 1'b0;
    if (mode == 3 && $urandom_range(0, 7) == 0) p[$urandom_range(0, NCH-1)] ^= 1'b1;
    return p;
  endfunction

  // ---------------- behavioural model of the default build ----------------
  logic           m_done = 1'b0, m_run = 1'b0;
  int             m_k = 0, m_err = 0, m_ff = 0;
  logic [NCH-1:0] m_mask = '0;
  int             m_idx;
  logic [NCH-1:0] m_diff;
  logic           cmp_en = 1'b0;

  always_comb begin
    m_idx  = m_run ? m_k : 0;
    m_diff = ch_m ^ exp_tab[m_idx];
  end

  always @(posedge clk or posedge rst_m) begin
    if (rst_m) begin
      m_done <= 1'b0; m_run <= 1'b0; m_k <= 0; m_err <= 0; m_ff <= 0; m_mask <= '0;
    end else if (!m_done && (m_run || start_m)) begin
      if (m_diff != '0) begin
        if (m_err == 0) m_ff <= m_idx;
        if (m_err < 65535) m_err <= m_err + 1;
        m_mask <= m_mask | m_diff;
      end
      m_k <= m_idx + 1;
      if (m_idx + 1 == NCASE) begin
        m_done <= 1'b1; m_run <= 1'b0;
      end else begin
        m_run <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_done",  done_m, m_done);
      check("cyc_pass",  pass_m, m_done && (m_err == 0));
      check("cyc_err",   err_m,  m_err);
      check("cyc_ff",    ff_m,   m_ff);
      check("cyc_mask",  mask_m, m_mask);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_m = 1'b1; start_m = 1'b0;
    @(posedge clk); #1 rst_m = 1'b0;
  endtask

  task automatic run_main(input int mode);
    @(posedge clk); #1 start_m = 1'b1; ch_m = pat(0, mode);
    for (int k = 1; k < NCASE; k++) begin
      @(posedge clk); #1 start_m = 1'b0; ch_m = pat(k, mode);
    end
    check("done_early", done_m, 1'b0);
    @(posedge clk); #1;
    check("done_latency", done_m, 1'b1);
    // Junk data and a spurious start after completion must change nothing.
    for (int i = 0; i < 5; i++) begin
      ch_m = rand70(); start_m = (i == 2);
      @(posedge clk); #1;
    end
    start_m = 1'b0;
  endtask

  // ---------------- saturation stimulus: every pattern inverted ----------------
  initial begin
    logic [31:0] s;
    rst_s = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_s = 1'b0;
    @(posedge clk); #1 start_s = 1'b1; s = SEED_V; ch_s = ~widen(s);
    for (int k = 1; k < NSAT; k++) begin
      @(posedge clk); #1 start_s = 1'b0; s = step(s); ch_s = ~widen(s);
    end
    @(posedge clk); #1;
    check("sat_done", done_s, 1'b1);
    check("sat_pass", pass_s, 1'b0);
    check("sat_err",  err_s,  16'hFFFF);
    check("sat_ff",   ff_s,   17'd0);
    check("sat_mask", mask_s, {NCH{1'b1}});
    sat_finished = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] s;
    int          cnt69, first69;
    s = SEED_V;
    for (int k = 0; k < NCASE; k++) begin
      exp_tab[k] = widen(s);
      s = step(s);
    end
    check("model_case0", exp_tab[0], 70'h2F_DEADBEEF_DEADBEEF);
    check("model_case1", exp_tab[1], 70'h34_EF76DF74_EF76DF74);

    rst_m = 1'b1; rst_1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_m = 1'b0; rst_1 = 1'b0;
    check("rst_done", done_m, 1'b0);
    check("rst_err",  err_m,  16'd0);
    check("rst_mask", mask_m, '0);
    cmp_en = 1'b1;

    // Idle with random data and no start: nothing may happen.
    for (int i = 0; i < 4; i++) begin
      ch_m = rand70(); @(posedge clk); #1;
    end

    // Clean loopback
    run_main(0);
    check("clean_pass", pass_m, 1'b1);
    check("clean_err",  err_m,  16'd0);
    check("clean_mask", mask_m, '0);

    // Single bit flip in case 17
    do_reset();
    run_main(1);
    check("flip_err",  err_m,  16'd1);
    check("flip_ff",   ff_m,   10'd17);
    check("flip_mask", mask_m, 70'h20);
    check("flip_pass", pass_m, 1'b0);

    // Bit 69 stuck at zero
    do_reset();
    run_main(2);
    cnt69 = 0; first69 = -1;
    for (int k = 0; k < NCASE; k++) begin
      if (exp_tab[k][69]) begin
        if (first69 < 0) first69 = k;
        cnt69++;
      end
    end
    check("stuck_mask", mask_m, {1'b1, {(NCH-1){1'b0}}});
    check("stuck_err",  err_m,  cnt69);
    check("stuck_ff",   ff_m,   first69);

    // Random sparse bit flips
    do_reset();
    run_main(3);

    // Reset in the middle of a run
    do_reset();
    @(posedge clk); #1 start_m = 1'b1; ch_m = exp_tab[0];
    for (int k = 1; k <= 500; k++) begin
      @(posedge clk); #1 start_m = 1'b0;
      ch_m = (k == 100) ? (exp_tab[k] ^ 70'h3) : exp_tab[k];
    end
    #2;
    check("abort_pre_err",  err_m,  16'd1);
    check("abort_pre_mask", mask_m, 70'h3);
    rst_m = 1'b1;
    #1;
    check("abort_done", done_m, 1'b0);
    check("abort_pass", pass_m, 1'b0);
    check("abort_err",  err_m,  16'd0);
    check("abort_ff",   ff_m,   10'd0);
    check("abort_mask", mask_m, '0);
    @(posedge clk); #1 rst_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_m = rand70(); @(posedge clk); #1;
    end
    check("abort_idle_done", done_m, 1'b0);
    run_main(0);
    check("abort_rerun_pass", pass_m, 1'b1);

    // Single-case build
    check("one_idle_done", done_1, 1'b0);
    @(posedge clk); #1 start_1 = 1'b1; ch_1 = exp_tab[0];
    @(posedge clk); #1 start_1 = 1'b0; ch_1 = rand70();
    check("one_done", done_1, 1'b1);
    check("one_pass", pass_1, 1'b1);
    check("one_err",  err_1,  16'd0);
    start_1 = 1'b1; ch_1 = ~exp_tab[0];
    @(posedge clk); #1 start_1 = 1'b0;
    @(posedge clk); #1;
    check("one_again_done", done_1, 1'b1);
    check("one_again_pass", pass_1, 1'b1);
    check("one_again_err",  err_1,  16'd0);
    check("one_again_mask", mask_1, '0);
    check("one_again_ff",   ff_1,   1'b0);

    // Wait (bounded) for the saturation build to finish.
    for (int i = 0; i < 80000 && !sat_finished; i++) @(posedge clk);
    #2;
    check("sat_finished", sat_finished, 1'b1);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bist_receiver
`default_nettype wire
